// File: rtl/aes_ct_pkg.sv
// Shared types and address decode for the AES ciphertext readout block.
package aes_ct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SCRUB = 2'd2
  } state_t;

  localparam int NUM_WORDS = 4;

  localparam logic [5:0] CT_IDX_W3 = 6'd5;
  localparam logic [5:0] CT_IDX_W2 = 6'd6;
  localparam logic [5:0] CT_IDX_W1 = 7;
  localparam logic [5:0] CT_IDX_W0 = 6'd8;

  typedef struct packed {
    logic       valid;
    logic [1:0] word;
  } word_sel_t;

  // Word 3 sits at the lowest address, so the map runs in reverse word order.
  function automatic word_sel_t idx_to_word(input logic [5:0] idx);
    word_sel_t sel;
    sel.valid = 1'b1;
    sel.word  = 2'd0;
    case (idx)
      CT_IDX_W3: sel.word = 2'd3;
      CT_IDX_W2: sel.word = 2'd2;
      CT_IDX_W1: sel.word = 2'd1;
      CT_IDX_W0: sel.word = 2'd0;
      default:   sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/aes_ct_readout_if.sv
// Cipher-core handshake plus register-bus signals of the ciphertext readout block.
// ct_valid_i/ct_ready_o: a transfer happens on a clock edge where both are high;
// the core keeps ct_i stable and ct_valid_i high until that edge.
interface aes_ct_readout_if #(parameter int ADDR_W = 9);
  import aes_ct_pkg::*;

  logic              ct_valid_i;
  logic [127:0]      ct_i;
  logic              ct_ready_o;
  logic              en_i;
  logic              we_i;
  logic [ADDR_W-1:0] address_i;
  logic [3:0]        reglk_ctrl_i;
  logic              clr_i;
  logic [31:0]       rdata_o;
  logic              rvalid_o;
  logic              ct_avail_o;
  logic              scrub_busy_o;
  state_t            dbg_state;

  modport slave (
    input  ct_valid_i, ct_i, en_i, we_i, address_i, reglk_ctrl_i, clr_i,
    output ct_ready_o, rdata_o, rvalid_o, ct_avail_o, scrub_busy_o, dbg_state
  );

  modport master (
    output ct_valid_i, ct_i, en_i, we_i, address_i, reglk_ctrl_i, clr_i,
    input  ct_ready_o, rdata_o, rvalid_o, ct_avail_o, scrub_busy_o, dbg_state
  );

endinterface

// File: rtl/aes_ct_timeout_ctr.sv
// Hold-time counter: clear wins over enable; o_tc flags the last allowed cycle.
module aes_ct_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/aes_ct_readout.sv
// Holds one ciphertext for read-once bus access and scrubs it on full read,
// timeout or software clear.
module aes_ct_readout
  import aes_ct_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  aes_ct_readout_if.slave       bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_ct_q [NUM_WORDS];
  logic [3:0]      r_read_mask;
  logic [1:0]      r_idx;
  logic [31:0]     r_rdata;
  logic            r_rvalid;

  logic            w_req;
  logic            w_tc;
  logic            w_hit;
  logic            w_capture;
  logic            w_scrub_done;
  logic            w_tmr_clr;
  logic [3:0]      w_mask_nxt;
  word_sel_t       w_sel;
  logic            w_unused_addr;

  assign w_unused_addr = ^bus.address_i[2:0];

  assign w_req = bus.en_i & ~bus.we_i;
  assign w_sel = idx_to_word(bus.address_i[8:3]);

  // A read racing a clear or the timeout is refused so nothing leaks on the way out.
  assign w_hit = w_req & (r_state == HOLD) & ~bus.clr_i & ~w_tc & w_sel.valid
               & ~bus.reglk_ctrl_i[w_sel.word] & ~r_read_mask[w_sel.word];
  assign w_mask_nxt = r_read_mask | (w_hit ? (4'b0001 << w_sel.word) : 4'b0000);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_scrub_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ct_valid_i) begin
          w_state_nxt = HOLD;
          w_capture   = 1'b1;
        end
      end
      HOLD: begin
        if (bus.clr_i || w_tc) begin
          w_state_nxt = SCRUB;
        end else if (w_mask_nxt == 4'hF) begin
          w_state_nxt = IDLE;
        end
      end
      SCRUB: begin
        if (r_idx == 2'd3) begin
          w_state_nxt  = IDLE;
          w_scrub_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Timer only runs while staying in HOLD; it sits at zero everywhere else.
  assign w_tmr_clr = (r_state != HOLD) || (w_state_nxt != HOLD);

  aes_ct_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_clr  (w_tmr_clr),
    .i_en   (r_state == HOLD),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_WORDS; k++) r_ct_q[k] <= '0;
      r_read_mask <= '0;
      r_idx       <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_rvalid <= w_req;
      r_rdata  <= w_hit ? r_ct_q[w_sel.word] : 32'h0;
      if (w_capture) begin
        for (int k = 0; k < NUM_WORDS; k++) r_ct_q[k] <= bus.ct_i[32*k +: 32];
        r_read_mask <= '0;
      end
      if (w_hit) begin
        r_ct_q[w_sel.word] <= '0;
        r_read_mask        <= w_mask_nxt;
      end
      if (r_state == SCRUB) begin
        r_ct_q[r_idx] <= '0;
        r_idx         <= r_idx + 2'd1;
        if (w_scrub_done) r_read_mask <= '0;
      end
    end
  end

  assign bus.ct_ready_o   = (r_state == IDLE);
  assign bus.ct_avail_o   = (r_state == HOLD);
  assign bus.scrub_busy_o = (r_state == SCRUB);
  assign bus.rdata_o      = r_rdata;
  assign bus.rvalid_o     = r_rvalid;
  assign bus.dbg_state    = r_state;

endmodule

// File: doc/aes_ct_readout.md
Name: aes_ct_readout

Overview:
Downstream stage of the AES plaintext/ciphertext register block. It accepts a 128-bit ciphertext from the cipher core on a valid/ready handshake and holds it for bus readout, subject to per-word read locks. Each word is read-once. Held data is scrubbed to zero on full readout, timeout, or software clear, so ciphertext never persists after use.

Parameters:
TIMEOUT_CYCLES, 1024, HOLD-state cycles before forced scrub (min 2)
ADDR_W, 9, bus address width; word select uses address_i[8:3]

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ct_valid_i  in  1  ciphertext valid from cipher core
ct_i  in  128  ciphertext; word k = ct_i[32k+31:32k]
ct_ready_o  out  1  block can accept ciphertext
en_i  in  1  bus access enable
we_i  in  1  bus write (writes ignored)
address_i  in  ADDR_W  bus address
reglk_ctrl_i  in  4  read lock per word, bit k locks word k
clr_i  in  1  software clear request
rdata_o  out  32  registered read data
rvalid_o  out  1  read response valid
ct_avail_o  out  1  ciphertext held (state HOLD)
scrub_busy_o  out  1  scrub in progress (state SCRUB)

Behaviour:
- Reset, asynchronous: ct_q[0..3]=0, read_mask=0, timer=0, idx=0, state=IDLE, rdata_o=0, rvalid_o=0. Derived outputs reset to ct_ready_o=1, ct_avail_o=0, scrub_busy_o=0.
- ct_ready_o = (state==IDLE). ct_avail_o = (state==HOLD). scrub_busy_o = (state==SCRUB).
- IDLE: ct_valid_i=1 captures ct_i into ct_q, clears read_mask and timer, and moves to HOLD. In any other state ct_valid_i is ignored; ready is low, so the core must hold its data.
- Read request = en_i & ~we_i. rvalid_o pulses exactly 1 cycle after every request, in any state. rdata_o is valid in the same cycle as rvalid_o and returns to 0 in the following cycle.
- Address map, address_i[8:3]: 5→word3, 6→word2, 7→word1, 8→word0. Any other index returns 0.
- HOLD read of word k returns ct_q[k] only if reglk_ctrl_i[k]==0 and read_mask[k]==0. Otherwise it returns 0.
- A successful read sets read_mask[k] and zeroes ct_q[k] on the same clock edge that registers rdata_o.
- HOLD exit priority, highest first:
  (1) clr_i=1 → SCRUB. A read in this same cycle returns 0.
  (2) timer==TIMEOUT_CYCLES-1 → SCRUB. A read in this same cycle returns 0.
  (3) read_mask becomes 4'hF → IDLE. All words are already zero.
  (4) Otherwise timer+1 and stay in HOLD.
- SCRUB: zeroes ct_q[idx] each cycle for idx=0..3, which takes 4 cycles. It then clears idx, read_mask and timer and moves to IDLE. Reads during SCRUB return 0. clr_i during SCRUB has no further effect.
- clr_i in IDLE: no state change. ct_q is already 0 there.
- Invariant: ct_q is all zero whenever state==IDLE.
- timer width is $clog2(TIMEOUT_CYCLES), counting from 0.
- Locked words are never returned. A locked word stays unread and is removed only by scrub.
- Reset mid-HOLD or mid-SCRUB: immediate return to the reset values; no partial data survives.

Decomposition:
- Package aes_ct_pkg:
  - state enum {IDLE, HOLD, SCRUB}
  - NUM_WORDS=4
  - CT_IDX_W3=5, CT_IDX_W2=6, CT_IDX_W1=7, CT_IDX_W0=8
  - function idx_to_word mapping address index to word number plus a valid flag
- Sub-module aes_ct_timeout_ctr: counter with clear and enable inputs and a terminal-count output at TIMEOUT_CYCLES-1.
- FSM, storage and read path stay in aes_ct_readout.

Test Plan:
- Reset, then ct_i=128'h0011..EEFF with ct_valid_i=1 → ct_ready_o drops next cycle, ct_avail_o=1. A read at index 5 returns 32'h0011_2233 with rvalid_o one cycle later.
- Read all four words with locks=0 → correct words returned. A re-read of index 6 returns 0. State returns to IDLE the cycle after the 4th read.
- reglk_ctrl_i=4'b0101, read all 4 → words 0 and 2 return 0. The FSM stays in HOLD and then scrubs at timeout (TIMEOUT_CYCLES=16 in the bench). Internal ct_q is all 0 after the 4 SCRUB cycles.
- clr_i asserted in the same cycle as a read of word 3 → rdata_o=0 and scrub_busy_o=1 for 4 cycles. A second ct_valid_i during SCRUB is held off, and is accepted once back in IDLE.
- Timeout boundary with TIMEOUT_CYCLES=16 and no reads → ct_avail_o high for exactly 16 cycles, then SCRUB. A read in the terminal cycle returns 0.
- Assert rst_ni low mid-HOLD → all outputs at their reset values immediately (rdata_o=0, rvalid_o=0, ct_avail_o=0, scrub_busy_o=0, ct_ready_o=1). After release, reads at indices 5–8 return 0.
